// File: rtl/uart_cmd_decoder_pkg.sv
// Shared SYS_CTRL definitions for the serial command decoder: state encodings,
// default protocol bytes and the latched bus request record.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_H   = 3'd1,
    ST_ADDR_L   = 3'd2,
    ST_DATA     = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_WAIT_RSP = 3'd5,
    ST_SEND     = 3'd6
  } state_e;

  localparam logic [7:0] OP_WR_DEF = 8'h57;
  localparam logic [7:0] OP_RD_DEF = 8'h52;
  localparam logic [7:0] ACK_DEF   = 8'h4B;

  // The serial frame always carries a 16-bit address regardless of bus width.
  localparam int FRAME_ADDR_W = 16;

  typedef struct packed {
    logic                    we;
    logic [FRAME_ADDR_W-1:0] addr;
    logic [7:0]              wdata;
  } cmd_req_t;

  function automatic logic is_opcode(input logic [7:0] b, input logic [7:0] wr,
                                     input logic [7:0] rd);
    return (b == wr) || (b == rd);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expired_o in the cycle the count reaches TIMEOUT-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT = 120000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // A clear in the expiring cycle means a byte arrived, which takes priority.
  assign expired_o = en_i & ~clr_i & (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     cnt_q <= '0;
    else if (clr_i || expired_o)   cnt_q <= '0;
    else if (en_i)                 cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles 'W'/'R' serial frames into single bus requests and returns one
// byte to the transmitter: read data for reads, ACK for writes.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter int         TIMEOUT = 120000,
  parameter logic [7:0] OP_WR   = OP_WR_DEF,
  parameter logic [7:0] OP_RD   = OP_RD_DEF,
  parameter logic [7:0] ACK     = ACK_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rcv_i,
  input  logic [7:0]        rx_data_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [7:0]        cmd_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [7:0]        rsp_data_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              err_opcode_o,
  output logic              err_timeout_o,
  output logic              err_overrun_o
);

  state_e     state_q, state_d;
  cmd_req_t   cmd_q, cmd_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       cmd_valid_q;
  logic       to_en, to_expired;

  assign to_en = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) || (state_q == ST_DATA);

  // ADDR_H is only ever entered on a received byte, so clearing on rcv also
  // covers the clear-on-entry case.
  uart_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (rcv_i),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    tx_data_d     = tx_data_q;
    err_opcode_o  = 1'b0;
    err_overrun_o = 1'b0;
    tx_start_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rcv_i) begin
          if (is_opcode(rx_data_i, OP_WR, OP_RD)) begin
            cmd_d.we = (rx_data_i == OP_WR);
            state_d  = ST_ADDR_H;
          end else begin
            err_opcode_o = 1'b1;
          end
        end
      end
      ST_ADDR_H: begin
        if (rcv_i) begin
          cmd_d.addr[15:8] = rx_data_i;
          state_d          = ST_ADDR_L;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_L: begin
        if (rcv_i) begin
          cmd_d.addr[7:0] = rx_data_i;
          state_d         = cmd_q.we ? ST_DATA : ST_ISSUE;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rcv_i) begin
          cmd_d.wdata = rx_data_i;
          state_d     = ST_ISSUE;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        err_overrun_o = rcv_i;
        if (cmd_valid_q && cmd_ready_i) begin
          if (cmd_q.we) begin
            tx_data_d = ACK;
            state_d   = ST_SEND;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        err_overrun_o = rcv_i;
        if (rsp_valid_i) begin
          tx_data_d = rsp_data_i;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        err_overrun_o = rcv_i;
        if (tx_ready_i) begin
          tx_start_o = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      tx_data_q   <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tx_data_q   <= tx_data_d;
      cmd_valid_q <= (state_d == ST_ISSUE);
    end
  end

  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_we_o      = cmd_q.we;
  assign cmd_wdata_o   = cmd_q.wdata;
  assign tx_data_o     = tx_data_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_timeout_o = to_expired;

  generate
    if (ADDR_W <= FRAME_ADDR_W) begin : g_addr_trunc
      assign cmd_addr_o = cmd_q.addr[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign cmd_addr_o = {{(ADDR_W-FRAME_ADDR_W){1'b0}}, cmd_q.addr};
    end
  endgenerate

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected bus requests and tx bytes are
// queued as frames are driven and popped when the DUT produces them.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcv;
  logic [7:0]  rx_data;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy, err_opcode, err_timeout, err_overrun;

  uart_cmd_decoder #(.ADDR_W(16), .TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rcv_i        (rcv),
    .rx_data_i    (rx_data),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .cmd_we_o     (cmd_we),
    .cmd_addr_o   (cmd_addr),
    .cmd_wdata_o  (cmd_wdata),
    .rsp_valid_i  (rsp_valid),
    .rsp_data_i   (rsp_data),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .err_opcode_o (err_opcode),
    .err_timeout_o(err_timeout),
    .err_overrun_o(err_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  cmd_req_t   exp_cmd_q[$];
  logic [7:0] exp_tx_q[$];
  int hs_cnt = 0, tx_cnt = 0, eop_cnt = 0, eto_cnt = 0, eov_cnt = 0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cmd_req_t   e;
    logic [7:0] t;
    if (cmd_valid && cmd_ready) begin
      hs_cnt++;
      if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        e = exp_cmd_q.pop_front();
        chk("cmd_we", {31'd0, cmd_we}, {31'd0, e.we});
        chk("cmd_addr", {16'd0, cmd_addr}, {16'd0, e.addr});
        if (e.we) chk("cmd_wdata", {24'd0, cmd_wdata}, {24'd0, e.wdata});
      end
    end
    if (tx_start) begin
      tx_cnt++;
      if (exp_tx_q.size() == 0) chk("tx_unexpected", 1, 0);
      else begin
        t = exp_tx_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, t});
      end
    end
    if (err_opcode)  eop_cnt++;
    if (err_timeout) eto_cnt++;
    if (err_overrun) eov_cnt++;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rcv     = 1'b1;
    rx_data = b;
    cyc(1);
    rcv     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 100) begin
      cyc(1);
      i++;
    end
    chk(tag, {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rcv = 1'b0; rx_data = '0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; tx_ready = 1'b1;
    cyc(2);
    chk("rst_busy",      {31'd0, busy},        0);
    chk("rst_cmd_valid", {31'd0, cmd_valid},   0);
    chk("rst_tx_start",  {31'd0, tx_start},    0);
    chk("rst_tx_data",   {24'd0, tx_data},     0);
    chk("rst_cmd_addr",  {16'd0, cmd_addr},    0);
    chk("rst_cmd_wdata", {24'd0, cmd_wdata},   0);
    chk("rst_cmd_we",    {31'd0, cmd_we},      0);
    chk("rst_err_to",    {31'd0, err_timeout}, 0);
    rst = 1'b0;
    cyc(2);

    // 1: write frame
    cmd_ready = 1'b1;
    exp_cmd_q.push_back('{we: 1'b1, addr: 16'h1234, wdata: 8'hA5});
    exp_tx_q.push_back(8'h4B);
    send(8'h57); send(8'h12); send(8'h34); send(8'hA5);
    chk("wr_latency", {31'd0, cmd_valid}, 1);
    wait_idle("wr_idle");
    chk("wr_hs_cnt", hs_cnt, 1);
    chk("wr_tx_cnt", tx_cnt, 1);

    // 2: read with bus backpressure
    cmd_ready = 1'b0;
    exp_cmd_q.push_back('{we: 1'b0, addr: 16'h00FF, wdata: 8'h00});
    exp_tx_q.push_back(8'h3C);
    send(8'h52); send(8'h00); send(8'hFF);
    for (int i = 0; i < 3; i++) begin
      chk("rd_valid_hold", {31'd0, cmd_valid}, 1);
      chk("rd_addr_hold", {16'd0, cmd_addr}, 32'h00FF);
      cyc(1);
    end
    cmd_ready = 1'b1;
    cyc(1);
    cmd_ready = 1'b0;
    chk("rd_valid_drop", {31'd0, cmd_valid}, 0);
    rsp_valid = 1'b1; rsp_data = 8'h3C;
    cyc(1);
    rsp_valid = 1'b0;
    wait_idle("rd_idle");
    chk("rd_hs_cnt", hs_cnt, 2);
    chk("rd_tx_cnt", tx_cnt, 2);

    // 3: bad opcode then a normal write
    cmd_ready = 1'b1;
    send(8'h00);
    chk("bad_opc_cnt", eop_cnt, 1);
    chk("bad_opc_busy", {31'd0, busy}, 0);
    exp_cmd_q.push_back('{we: 1'b1, addr: 16'h0001, wdata: 8'h02});
    exp_tx_q.push_back(8'h4B);
    send(8'h57); send(8'h00); send(8'h01); send(8'h02);
    wait_idle("bad_idle");
    chk("bad_hs_cnt", hs_cnt, 3);
    chk("bad_opc_cnt2", eop_cnt, 1);

    // 4: inter-byte timeout, then a read decodes cleanly
    send(8'h57); send(8'h12);
    cyc(14);
    chk("to_early", {31'd0, err_timeout}, 0);
    cyc(1);
    chk("to_pulse", {31'd0, err_timeout}, 1);
    cyc(1);
    chk("to_busy", {31'd0, busy}, 0);
    chk("to_cnt", eto_cnt, 1);
    exp_cmd_q.push_back('{we: 1'b0, addr: 16'h0000, wdata: 8'h00});
    exp_tx_q.push_back(8'h5A);
    send(8'h52); send(8'h00); send(8'h00);
    cyc(1);
    rsp_valid = 1'b1; rsp_data = 8'h5A;
    cyc(1);
    rsp_valid = 1'b0;
    wait_idle("to_rd_idle");
    chk("to_hs_cnt", hs_cnt, 4);
    chk("to_tx_cnt", tx_cnt, 4);

    // 5: overrun during WAIT_RSP and transmitter backpressure
    tx_ready = 1'b0;
    exp_cmd_q.push_back('{we: 1'b0, addr: 16'hABCD, wdata: 8'h00});
    exp_tx_q.push_back(8'h77);
    send(8'h52); send(8'hAB); send(8'hCD);
    cyc(1);
    send(8'h99);
    chk("ovr_cnt", eov_cnt, 1);
    chk("ovr_busy", {31'd0, busy}, 1);
    rsp_valid = 1'b1; rsp_data = 8'h77;
    cyc(1);
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_start", {31'd0, tx_start}, 0);
      cyc(1);
    end
    tx_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_tx_cnt", tx_cnt, 5);
    chk("ovr_cnt2", eov_cnt, 1);

    // 6: reset during ISSUE
    cmd_ready = 1'b0;
    send(8'h57); send(8'hDE); send(8'hAD); send(8'h01);
    chk("rst_pre_valid", {31'd0, cmd_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, cmd_valid}, 0);
    chk("rst_async_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_ready = 1'b1;
    cyc(5);
    chk("rst_hs_cnt", hs_cnt, 5);
    chk("rst_tx_cnt", tx_cnt, 5);
    chk("rst_post_valid", {31'd0, cmd_valid}, 0);

    chk("sb_cmd_empty", exp_cmd_q.size(), 0);
    chk("sb_tx_empty", exp_tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
